mux_n_1_rr: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer. Successor to the combinational 4:1 mux. Each input channel has a valid/ready handshake. One channel is granted per cycle, either by a fixed select or by round-robin arbitration. The granted word is captured into a single output register that has its own valid/ready handshake. The block sits between several producer streams and one consumer, such as a shared bus or logger, and replaces ad-hoc combinational muxes where back-pressure is needed.

---
 rtl/mux_n_1_rr_pkg.sv | 13 +
 rtl/mux_n_1_rr_if.sv | 31 +++
 rtl/mux_n_1_rr_arbiter.sv | 33 +++
 rtl/mux_n_1_rr.sv | 112 +++++++++++
 tb/tb_mux_n_1_rr.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_1_rr_pkg.sv
// Shared constants and helpers for the N:1 registered round-robin mux.
// Package name: mux_pkg.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index for n channels (at least one bit)
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_1_rr_if.sv
// Producer/consumer handshake bundle for mux_n_1_rr.
// slave modport: the mux itself; master modport: the producers and consumer around it.
interface mux_n_1_rr_if
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = sel_width(NUM_CH)
);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_n_1_rr_arbiter.sv
// Round-robin request scanner: first requester at or after i_ptr, modulo NUM_CH.
// Only instantiated when MUX_N_1_RR_EN is defined.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int SEL_W = sel_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant_oh,
  output logic [SEL_W-1:0]  o_grant_idx,
  output logic              o_grant_any
);

  // Scan ptr, ptr+1, ... with wrap; the first hit wins
  always_comb begin : p_scan
    int v_idx;
    v_idx       = 0;
    o_grant_oh  = '0;
    o_grant_idx = '0;
    o_grant_any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      v_idx = (int'(i_ptr) + k) % NUM_CH;
      if (!o_grant_any && i_req[SEL_W'(v_idx)]) begin
        o_grant_any = 1'b1;
        o_grant_idx = SEL_W'(v_idx);
      end
    end
    if (o_grant_any) o_grant_oh[o_grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// N-channel, W-bit registered mux with per-channel valid/ready and an output
// register with its own valid/ready. Fixed select always available; round-robin
// arbitration (and the ptr register) exists only when MUX_N_1_RR_EN is defined.
module mux_n_1_rr
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = sel_width(NUM_CH)
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_n_1_rr_if.slave bus
);

  logic              w_load_en;
  logic              w_xfer;
  logic              w_grant_any;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [NUM_CH-1:0] w_grant_oh;
  logic [DATA_W-1:0] w_grant_data;
  logic              w_fix_any;
  logic [NUM_CH-1:0] w_fix_oh;

  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_ch;
  logic              r_out_valid;

  // The register can take a word when empty or being drained this cycle
  assign w_load_en = !r_out_valid || bus.out_ready;

  // Fixed select: only an in-range channel that is valid gets the grant
  always_comb begin
    w_fix_any = 1'b0;
    w_fix_oh  = '0;
    if (int'(bus.sel) < NUM_CH) begin
      w_fix_any          = bus.in_valid[bus.sel];
      w_fix_oh[bus.sel]  = bus.in_valid[bus.sel];
    end
  end

`ifdef MUX_N_1_RR_EN
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  w_rr_idx;
  logic [NUM_CH-1:0] w_rr_oh;
  logic              w_rr_any;
  logic              w_rr_active;

  assign w_rr_active = (bus.mode == MODE_RR);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .i_req       (bus.in_valid),
    .i_ptr       (r_ptr),
    .o_grant_oh  (w_rr_oh),
    .o_grant_idx (w_rr_idx),
    .o_grant_any (w_rr_any)
  );

  assign w_grant_any = w_rr_active ? w_rr_any : w_fix_any;
  assign w_grant_idx = w_rr_active ? w_rr_idx : bus.sel;
  assign w_grant_oh  = w_rr_active ? w_rr_oh  : w_fix_oh;

  // Pointer moves just past the winner, only on round-robin transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer && w_rr_active) begin
      r_ptr <= (int'(w_grant_idx) == NUM_CH - 1) ? '0 : w_grant_idx + 1'b1;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = bus.mode;

  assign w_grant_any = w_fix_any;
  assign w_grant_idx = bus.sel;
  assign w_grant_oh  = w_fix_oh;
`endif

  assign w_xfer = w_grant_any && w_load_en;

  // Ready goes only to the granted channel, and never while in reset
  assign bus.in_ready = w_grant_oh & {NUM_CH{w_load_en && rst_n}};

  // Pick the granted channel's word from the one-hot grant
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant_oh[i]) w_grant_data = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  // Output register: load on transfer, empty on drain without a new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_ch    <= w_grant_idx;
    end else if (w_load_en && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: a spec-level model pushes expected words
// when a transfer should happen; a separate monitor checks the output register.
module tb_mux_n_1_rr;

  localparam int NCH = 4;
  localparam int DW  = 8;
`ifdef MUX_N_1_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    ch;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  exp_t q[$];
  bit   m_ov;
  int   m_ptr;

  mux_n_1_rr_if #(.NUM_CH(NCH), .DATA_W(DW)) bus();

  mux_n_1_rr #(.NUM_CH(NCH), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Evaluated mid-cycle: decide grant from the rules, check in_ready, and
  // advance the model state to what it will be after the next rising edge.
  task automatic model_eval();
    bit         ld;
    bit         any;
    bit         rr;
    int         g;
    int         c;
    logic [3:0] exp_rdy;
    exp_t       e;
    exp_rdy = '0;
    any     = 1'b0;
    g       = 0;
    if (rst_n) begin
      ld = !m_ov || bus.out_ready;
      rr = RR_EN && bus.mode;
      if (rr) begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (!any && bus.in_valid[c]) begin
            any = 1'b1;
            g   = c;
          end
        end
      end else if (int'(bus.sel) < NCH && bus.in_valid[bus.sel]) begin
        any = 1'b1;
        g   = int'(bus.sel);
      end
      if (any && ld) begin
        exp_rdy[g] = 1'b1;
        e.d  = bus.in_data[g*DW +: DW];
        e.ch = 2'(g);
        q.push_back(e);
        m_ov = 1'b1;
        if (rr) m_ptr = (g + 1) % NCH;
      end else if (ld && bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_model();
    q.delete();
    m_ov  = 1'b0;
    m_ptr = 0;
  endtask

  // Monitor: runs after inputs settle, compares whatever the register presents
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      vectors++;
      if (bus.out_valid === 1'b1) begin
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL out_valid: got 1, expected 0 (no word pending)");
        end else begin
          e = q[0];
          if (bus.out_data !== e.d || bus.out_ch !== e.ch) begin
            miscompares++;
            $display("FAIL out_word: got data=%0h ch=%0d, expected data=%0h ch=%0d",
                     bus.out_data, bus.out_ch, e.d, e.ch);
          end
          if (bus.out_ready) void'(q.pop_front());
        end
      end else if (q.size() != 0) begin
        miscompares++;
        $display("FAIL out_valid: got %b, expected 1 (word pending)", bus.out_valid);
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    do_reset_model();
    rst_n         = 1'b0;
    bus.in_data   = 32'h44_33_22_11;
    bus.in_valid  = 4'hF;
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b1;

    // Reset holds everything quiet even with all channels valid
    #2;
    chk("rst in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst out_data", 32'(bus.out_data), 32'h0);
    chk("rst out_ch", 32'(bus.out_ch), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Fixed mode, channel 2
    bus.sel      = 2'd2;
    bus.in_data  = 32'h00_A5_00_00;
    bus.in_valid = 4'b0100;
    step();
    chk("fixed out_data", 32'(bus.out_data), 32'hA5);
    chk("fixed out_ch", 32'(bus.out_ch), 32'd2);
    bus.sel = 2'd3;
    step();
    chk("fixed idle out_valid", 32'(bus.out_valid), 32'h0);

    // Back-pressure: hold for three cycles, then drain and load together
    bus.sel      = 2'd1;
    bus.in_valid = 4'b0010;
    bus.in_data  = 32'h00_00_3C_00;
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = $urandom();
      step();
      chk("bp out_data", 32'(bus.out_data), 32'h3C);
    end
    bus.out_ready = 1'b1;
    bus.in_data   = 32'h00_00_C3_00;
    step();
    chk("drain+load out_data", 32'(bus.out_data), 32'hC3);
    chk("drain+load out_valid", 32'(bus.out_valid), 32'h1);

    // Round-robin: all valid, then skip and wrap
    bus.mode     = 1'b1;
    bus.sel      = 2'd0;
    bus.in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = $urandom();
      step();
    end
    bus.in_valid = 4'b0100;
    step();
    bus.in_valid = 4'b0101;
    step();
    step();
    if (RR_EN) chk("rr wrap out_ch", 32'(bus.out_ch), 32'd2);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_data   = $urandom();
      bus.in_valid  = 4'($urandom());
      bus.sel       = 2'($urandom());
      bus.mode      = 1'($urandom());
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset mid-stream with a word held
    bus.mode      = 1'b1;
    bus.sel       = 2'd1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 4'b0000;
    step();
    step();
    bus.in_valid = 4'b0010;
    bus.in_data  = 32'h00_00_77_00;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'hF;
    rst_n = 1'b0;
    do_reset_model();
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'h0);
    chk("async rst out_data", 32'(bus.out_data), 32'h0);
    chk("async rst in_ready", 32'(bus.in_ready), 32'h0);
    step();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    bus.sel       = 2'd3;
    step();
    chk("post-rst out_ch", 32'(bus.out_ch), RR_EN ? 32'd0 : 32'd3);

    // Drain and confirm nothing is left pending
    bus.in_valid = 4'h0;
    step();
    step();
    chk("queue empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
